// File: rtl/pwm_deadtime_inserter_if.sv
// Control and gate-drive bundle between the PWM source and the dead-time inserter.
interface pwm_deadtime_inserter_if #(
    parameter int DT_WIDTH = 8
);
    logic                enable;
    logic                pwm_in;
    logic [DT_WIDTH-1:0] dead_time;
    logic                fault;
    logic                fault_clr;
    logic                pwm_hi;
    logic                pwm_lo;
    logic                in_deadband;
    logic                fault_latched;

    modport master (
        output enable, pwm_in, dead_time, fault, fault_clr,
        input  pwm_hi, pwm_lo, in_deadband, fault_latched
    );

    modport slave (
        input  enable, pwm_in, dead_time, fault, fault_clr,
        output pwm_hi, pwm_lo, in_deadband, fault_latched
    );
endinterface

// File: rtl/pwm_deadtime_inserter.sv
// Turns a single-ended PWM into a complementary gate pair with a programmable
// dead band on every edge and a sticky fault shutdown.
module pwm_deadtime_inserter #(
    parameter int DT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pwm_deadtime_inserter_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DEAD_TO_HI = 3'd1,
        HI_ON      = 3'd2,
        DEAD_TO_LO = 3'd3,
        LO_ON      = 3'd4,
        FAULT      = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DT_WIDTH-1:0] dt_q, dt_d;
    logic                pwm_hi_q, pwm_hi_d;
    logic                pwm_lo_q, pwm_lo_d;
    logic                in_deadband_q, in_deadband_d;
    logic                fault_latched_q, fault_latched_d;
    logic                band_done;
    logic                band_entry;
    logic                dead_next;

    // dt_q is always >= 1 once a band is entered, so dt_q-1 never underflows there
    assign band_done = (cnt_q == (dt_q - DT_WIDTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            dt_q            <= '0;
            pwm_hi_q        <= 1'b0;
            pwm_lo_q        <= 1'b0;
            in_deadband_q   <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            dt_q            <= dt_d;
            pwm_hi_q        <= pwm_hi_d;
            pwm_lo_q        <= pwm_lo_d;
            in_deadband_q   <= in_deadband_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.fault) begin
            state_d = FAULT;
        end else if (state_q == FAULT) begin
            if (bus.fault_clr) state_d = IDLE;
        end else if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:       state_d = bus.pwm_in ? DEAD_TO_HI : DEAD_TO_LO;
                // A reversal inside a band hands straight back to the gate that was on.
                DEAD_TO_HI: begin
                    if (!bus.pwm_in)    state_d = LO_ON;
                    else if (band_done) state_d = HI_ON;
                end
                HI_ON:      if (!bus.pwm_in) state_d = DEAD_TO_LO;
                DEAD_TO_LO: begin
                    if (bus.pwm_in)     state_d = HI_ON;
                    else if (band_done) state_d = LO_ON;
                end
                LO_ON:      if (bus.pwm_in) state_d = DEAD_TO_HI;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dead_next  = (state_d == DEAD_TO_HI) || (state_d == DEAD_TO_LO);
        band_entry = dead_next && (state_d != state_q);
        dt_d       = dt_q;
        cnt_d      = '0;
        if (band_entry) begin
            dt_d = (bus.dead_time == '0) ? DT_WIDTH'(1) : bus.dead_time;
        end else if (dead_next) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + DT_WIDTH'(1);
        end
    end

    always_comb begin
        pwm_hi_d        = (state_d == HI_ON);
        pwm_lo_d        = (state_d == LO_ON);
        in_deadband_d   = (state_d == DEAD_TO_HI) || (state_d == DEAD_TO_LO);
        fault_latched_d = (state_d == FAULT);
    end

    assign bus.pwm_hi        = pwm_hi_q;
    assign bus.pwm_lo        = pwm_lo_q;
    assign bus.in_deadband   = in_deadband_q;
    assign bus.fault_latched = fault_latched_q;
endmodule

// File: tb/tb_pwm_deadtime_inserter.sv
// Directed bench: each step drives inputs at the falling edge and queues the gate
// state expected after the next rising edge; a checker pops and compares it.
module tb_pwm_deadtime_inserter;
    localparam int DT_WIDTH = 8;

    // Expected output vectors {pwm_hi, pwm_lo, in_deadband, fault_latched}
    localparam logic [3:0] E_IDLE = 4'b0000;
    localparam logic [3:0] E_HI   = 4'b1000;
    localparam logic [3:0] E_LO   = 4'b0100;
    localparam logic [3:0] E_DB   = 4'b0010;
    localparam logic [3:0] E_FL   = 4'b0001;

    typedef struct {
        logic [3:0] exp;
        string      tag;
    } sb_t;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_step   = 0;
    sb_t  sb_q[$];
    sb_t  cur;
    logic [3:0] obs;

    pwm_deadtime_inserter_if #(.DT_WIDTH(DT_WIDTH)) bus ();

    pwm_deadtime_inserter #(.DT_WIDTH(DT_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            n_assert++;
            assert (!(bus.pwm_hi === 1'b1 && bus.pwm_lo === 1'b1)) else begin
                n_fail++;
                $error("FAIL overlap: observed hi=%b lo=%b required not both 1", bus.pwm_hi, bus.pwm_lo);
            end
        end
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            obs = {bus.pwm_hi, bus.pwm_lo, bus.in_deadband, bus.fault_latched};
            n_step++;
            n_assert++;
            $display("step %0d %s: hi/lo/db/fl observed %b expected %b", n_step, cur.tag, obs, cur.exp);
            assert (obs === cur.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", cur.tag, obs, cur.exp);
            end
        end
    end

    task automatic cyc(input logic en, input logic pwm, input logic [DT_WIDTH-1:0] dt,
                       input logic flt, input logic clr, input logic [3:0] exp, input string tag);
        sb_t item;
        @(negedge clk);
        bus.enable    = en;
        bus.pwm_in    = pwm;
        bus.dead_time = dt;
        bus.fault     = flt;
        bus.fault_clr = clr;
        item.exp = exp;
        item.tag = tag;
        sb_q.push_back(item);
    endtask

    task automatic cycn(input int n, input logic en, input logic pwm, input logic [DT_WIDTH-1:0] dt,
                        input logic flt, input logic clr, input logic [3:0] exp, input string tag);
        for (int i = 0; i < n; i++) cyc(en, pwm, dt, flt, clr, exp, tag);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.enable    = 1'b0;
        bus.pwm_in    = 1'b0;
        bus.dead_time = '0;
        bus.fault     = 1'b0;
        bus.fault_clr = 1'b0;
        #2;
        obs = {bus.pwm_hi, bus.pwm_lo, bus.in_deadband, bus.fault_latched};
        n_assert++;
        assert (obs === E_IDLE) else begin
            n_fail++;
            $error("FAIL reset: observed %b expected %b", obs, E_IDLE);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Disabled: stays idle
        cycn(2, 0, 0, 8'd4, 0, 0, E_IDLE, "idle_hold");

        // 1: enable gives full band, then dead_time=4 rising edge from LO_ON
        cyc (   1, 0, 8'd4, 0, 0, E_DB, "t1_en_db");
        cycn(3, 1, 0, 8'd4, 0, 0, E_DB, "t1_en_db");
        cycn(3, 1, 0, 8'd4, 0, 0, E_LO, "t1_lo");
        cycn(4, 1, 1, 8'd4, 0, 0, E_DB, "t1_rise_db");
        cycn(2, 1, 1, 8'd4, 0, 0, E_HI, "t1_hi");

        // 2: dead_time=0 behaves as one cycle; reversal inside the band
        cyc(1, 0, 8'd0, 0, 0, E_DB, "t2_fall_db");
        cyc(1, 0, 8'd0, 0, 0, E_LO, "t2_lo");
        cyc(1, 1, 8'd0, 0, 0, E_DB, "t2_rise_db");
        cyc(1, 1, 8'd0, 0, 0, E_HI, "t2_hi");
        cyc(1, 0, 8'd0, 0, 0, E_DB, "t2_alt_db");
        cyc(1, 1, 8'd0, 0, 0, E_HI, "t2_abort_hi");
        cyc(1, 0, 8'd0, 0, 0, E_DB, "t2_fall_db2");
        cyc(1, 0, 8'd0, 0, 0, E_LO, "t2_lo2");

        // 3: 3-cycle pulse shorter than dead_time=6 is absorbed
        cyc (   1, 0, 8'd6, 0, 0, E_LO, "t3_lo");
        cycn(3, 1, 1, 8'd6, 0, 0, E_DB, "t3_pulse_db");
        cyc (   1, 0, 8'd6, 0, 0, E_LO, "t3_abort_lo");
        cycn(2, 1, 0, 8'd6, 0, 0, E_LO, "t3_lo_hold");
        // dead_time changed mid band keeps the latched length
        cyc (   1, 1, 8'd6, 0, 0, E_DB, "t3b_db");
        cycn(5, 1, 1, 8'd2, 0, 0, E_DB, "t3b_db_dtchg");
        cyc (   1, 1, 8'd2, 0, 0, E_HI, "t3b_hi");

        // 4: fault from HI_ON, clear ignored while fault held, then full band
        cyc (   1, 1, 8'd2, 1, 0, E_FL,   "t4_fault");
        cyc (   1, 1, 8'd2, 1, 1, E_FL,   "t4_clr_ignored");
        cyc (   0, 1, 8'd2, 0, 0, E_FL,   "t4_fl_hold");
        cyc (   1, 1, 8'd2, 0, 1, E_IDLE, "t4_clr");
        cycn(2, 1, 1, 8'd2, 0, 0, E_DB,   "t4_db");
        cyc (   1, 1, 8'd2, 0, 0, E_HI,   "t4_hi");
        // fault wins over enable=0
        cyc (   0, 1, 8'd2, 1, 0, E_FL,   "t4_fault_dis");
        cyc (   1, 1, 8'd2, 0, 1, E_IDLE, "t4_clr2");
        cycn(2, 1, 1, 8'd2, 0, 0, E_DB,   "t4_db2");
        cyc (   1, 1, 8'd2, 0, 0, E_HI,   "t4_hi2");

        // 5: disable mid band, re-enable with pwm_in=1
        cycn(2, 1, 0, 8'd5, 0, 0, E_DB,   "t5_db");
        cyc (   0, 0, 8'd5, 0, 0, E_IDLE, "t5_disable");
        cyc (   0, 1, 8'd5, 0, 0, E_IDLE, "t5_idle");
        cycn(3, 1, 1, 8'd3, 0, 0, E_DB,   "t5_reen_db");
        cyc (   1, 1, 8'd3, 0, 0, E_HI,   "t5_hi");

        // 6: async reset in HI_ON clears outputs with no clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        obs = {bus.pwm_hi, bus.pwm_lo, bus.in_deadband, bus.fault_latched};
        n_assert++;
        assert (obs === E_IDLE) else begin
            n_fail++;
            $error("FAIL t6_async_rst: observed %b expected %b", obs, E_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycn(3, 0, 1, 8'd1, 0, 0, E_IDLE, "t6_idle");
        cyc (   1, 1, 8'd1, 0, 0, E_DB,   "t6_db");
        cyc (   1, 1, 8'd1, 0, 0, E_HI,   "t6_hi");

        // 7: maximum dead_time, counter must not wrap
        cycn(255, 1, 0, 8'd255, 0, 0, E_DB, "t7_db255");
        cyc (     1, 0, 8'd255, 0, 0, E_LO, "t7_lo");

        @(posedge clk);
        #2;
        n_assert++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: observed %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
